// File: rtl/manchester_frame_sync_pkg.sv
// Shared definitions for the Manchester receive framer: state encoding, default sync word,
// and the single-bit step function that the top applies once per decoded bit.
package manchester_frame_sync_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2
   } rx_state_t;

   localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hD391;

   typedef struct packed {
      rx_state_t   state;
      logic [15:0] hist;
      logic [7:0]  shift;
      logic [2:0]  bitcnt;
      logic [7:0]  len_rem;
   } rx_ctx_t;

   typedef struct packed {
      rx_ctx_t     ctx;
      logic        sync;
      logic        emit;
      logic        last;
      logic [7:0]  data;
   } rx_step_t;

   function automatic rx_step_t rx_step(input rx_ctx_t c, input logic b,
                                        input logic [15:0] sync_word);
      rx_step_t    r;
      logic [15:0] hist_n;
      logic [7:0]  byte_n;
      r      = '0;
      r.ctx  = c;
      hist_n = {c.hist[14:0], b};
      byte_n = {c.shift[6:0], b};
      case (c.state)
         HUNT: begin
            r.ctx.hist = hist_n;
            if (hist_n == sync_word) begin
               r.ctx.state  = LEN;
               r.ctx.bitcnt = '0;
               r.sync       = 1'b1;
            end
         end
         LEN: begin
            r.ctx.shift  = byte_n;
            r.ctx.bitcnt = c.bitcnt + 3'd1;
            if (c.bitcnt == 3'd7) begin
               if (byte_n == '0) begin
                  r.ctx.state = HUNT;
                  r.ctx.hist  = '0;
               end else begin
                  r.ctx.len_rem = byte_n;
                  r.ctx.state   = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            r.ctx.shift  = byte_n;
            r.ctx.bitcnt = c.bitcnt + 3'd1;
            if (c.bitcnt == 3'd7) begin
               r.emit        = 1'b1;
               r.data        = byte_n;
               r.ctx.len_rem = c.len_rem - 8'd1;
               if (c.len_rem == 8'd1) begin
                  r.last      = 1'b1;
                  r.ctx.state = HUNT;
                  r.ctx.hist  = '0;
               end
            end
         end
         default: r.ctx.state = HUNT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/manchester_frame_sync_rx_bit_gather.sv
// Splits a 0/1/2-bit decoder beat into up to two single-bit steps in arrival order.
module rx_bit_gather
   import manchester_frame_sync_pkg::*;
(
   input  logic [1:0] decoded_bits,
   input  logic [1:0] num_decoded_bits,
   output logic       step0_valid,
   output logic       step1_valid,
   output logic       bit0,
   output logic       bit1,
   output logic       illegal
);

   always_comb begin
      step0_valid = 1'b0;
      step1_valid = 1'b0;
      bit0        = 1'b0;
      bit1        = 1'b0;
      illegal     = 1'b0;
      case (num_decoded_bits)
         2'd1: begin
            step0_valid = 1'b1;
            bit0        = decoded_bits[0];
         end
         2'd2: begin
            step0_valid = 1'b1;
            step1_valid = 1'b1;
            bit0        = decoded_bits[1];
            bit1        = decoded_bits[0];
         end
         2'd3:    illegal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/manchester_frame_sync.sv
// Sync-word hunter and length-prefixed byte framer behind the Manchester decoder (clk_100).
module manchester_frame_sync
   import manchester_frame_sync_pkg::*;
#(
   parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic [1:0] decoded_bits,
   input  logic [1:0] num_decoded_bits,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   output logic       m_axis_tlast,
   output logic       locked,
   output logic       sync_det,
   output logic       frame_abort
);

   logic     step0_valid, step1_valid, bit0, bit1, illegal;
   rx_ctx_t  ctx_q, ctx_d;
   rx_step_t s0, s1;
   logic     sync_d, emit_d, last_d, abort_d;
   logic [7:0] data_d;

   rx_bit_gather u_gather (
      .decoded_bits     (decoded_bits),
      .num_decoded_bits (num_decoded_bits),
      .step0_valid      (step0_valid),
      .step1_valid      (step1_valid),
      .bit0             (bit0),
      .bit1             (bit1),
      .illegal          (illegal)
   );

   // Two chained single-bit steps per cycle so a state change on the first bit
   // is already in effect for the second one.
   always_comb begin
      ctx_d   = ctx_q;
      s0      = '0;
      s1      = '0;
      sync_d  = 1'b0;
      emit_d  = 1'b0;
      last_d  = 1'b0;
      abort_d = 1'b0;
      data_d  = '0;
      if (illegal) begin
         if (ctx_q.state != HUNT) begin
            ctx_d.state   = HUNT;
            ctx_d.hist    = '0;
            ctx_d.bitcnt  = '0;
            ctx_d.shift   = '0;
            ctx_d.len_rem = '0;
            abort_d       = 1'b1;
         end
      end else begin
         if (step0_valid) begin
            s0    = rx_step(ctx_d, bit0, SYNC_WORD);
            ctx_d = s0.ctx;
         end
         if (step1_valid) begin
            s1    = rx_step(ctx_d, bit1, SYNC_WORD);
            ctx_d = s1.ctx;
         end
         sync_d = s0.sync | s1.sync;
         emit_d = s0.emit | s1.emit;
         last_d = s0.last | s1.last;
         data_d = s0.emit ? s0.data : s1.data;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ctx_q         <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         locked        <= 1'b0;
         sync_det      <= 1'b0;
         frame_abort   <= 1'b0;
      end else begin
         ctx_q         <= ctx_d;
         m_axis_tvalid <= emit_d;
         m_axis_tlast  <= last_d;
         sync_det      <= sync_d;
         frame_abort   <= abort_d;
         locked        <= (ctx_d.state == LEN) || (ctx_d.state == PAYLOAD);
         if (emit_d) m_axis_tdata <= data_d;
      end
   end

endmodule

// File: tb/tb_manchester_frame_sync.sv
// Bench for manchester_frame_sync: frames are built as tagged bit queues, and the expected
// output events (byte, sync, abort) are timed from the cycle each tagged bit is delivered.
module tb_manchester_frame_sync;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic [1:0] decoded_bits = '0;
   logic [1:0] num_decoded_bits = '0;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid, m_axis_tlast, locked, sync_det, frame_abort;

   manchester_frame_sync #(.SYNC_WORD(16'hD391)) dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .decoded_bits     (decoded_bits),
      .num_decoded_bits (num_decoded_bits),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tlast     (m_axis_tlast),
      .locked           (locked),
      .sync_det         (sync_det),
      .frame_abort      (frame_abort)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      logic       b;
      logic       sync_end;
      logic       byte_end;
      logic [7:0] data;
      logic       last;
   } tbit_t;
   typedef struct {
      int         c;
      logic [7:0] data;
      logic       last;
   } exp_byte_t;
   typedef struct {
      logic [7:0] data;
      logic       last;
   } rec_t;

   tbit_t     bits_q[$];
   exp_byte_t exp_bytes[$];
   int        exp_sync[$];
   int        exp_abort[$];
   rec_t      rec[$];
   int        tests = 0, fails = 0;
   int        sync_cnt = 0, last_cnt = 0, abort_cnt = 0;
   bit        chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic push_raw(input logic b);
      tbit_t t;
      t.b = b; t.sync_end = 1'b0; t.byte_end = 1'b0; t.data = '0; t.last = 1'b0;
      bits_q.push_back(t);
   endtask

   task automatic push_byte(input logic [7:0] v, input bit payload, input bit last);
      for (int i = 7; i >= 0; i--) begin
         tbit_t t;
         t.b = v[i]; t.sync_end = 1'b0; t.byte_end = payload && (i == 0);
         t.data = v; t.last = last;
         bits_q.push_back(t);
      end
   endtask

   task automatic push_hdr(input logic [7:0] len);
      logic [15:0] sw;
      sw = 16'hD391;
      for (int i = 15; i >= 0; i--) begin
         tbit_t t;
         t.b = sw[i]; t.sync_end = (i == 0); t.byte_end = 1'b0; t.data = '0; t.last = 1'b0;
         bits_q.push_back(t);
      end
      push_byte(len, 1'b0, 1'b0);
   endtask

   // mode 0: random 0..2 bits per cycle, otherwise fixed bits per cycle
   task automatic drive(input int mode, input int max_bits);
      int sent, n;
      sent = 0;
      while (bits_q.size() > 0 && sent < max_bits) begin
         @(posedge aclk); #1;
         n = (mode == 0) ? int'($urandom_range(2, 0)) : mode;
         if (n > bits_q.size()) n = bits_q.size();
         if (n > max_bits - sent) n = max_bits - sent;
         decoded_bits     = 2'($urandom);
         num_decoded_bits = 2'(n);
         for (int k = 0; k < n; k++) begin
            tbit_t t;
            exp_byte_t e;
            t = bits_q.pop_front();
            if (n == 2) decoded_bits[1-k] = t.b;
            else        decoded_bits[0]   = t.b;
            if (t.sync_end) exp_sync.push_back(cyc + 1);
            if (t.byte_end) begin
               e.c = cyc + 1; e.data = t.data; e.last = t.last;
               exp_bytes.push_back(e);
            end
            sent++;
         end
      end
      @(posedge aclk); #1;
      num_decoded_bits = '0;
   endtask

   task automatic send_abort();
      @(posedge aclk); #1;
      decoded_bits     = 2'($urandom);
      num_decoded_bits = 2'd3;
      exp_abort.push_back(cyc + 1);
      @(posedge aclk); #1;
      num_decoded_bits = '0;
   endtask

   task automatic settle(input string name);
      repeat (6) @(posedge aclk);
      #1;
      chk({name, "_pending_bytes"}, exp_bytes.size(), 0);
      chk({name, "_pending_sync"}, exp_sync.size(), 0);
      chk({name, "_pending_abort"}, exp_abort.size(), 0);
      chk({name, "_locked_idle"}, locked, 1'b0);
   endtask

   task automatic clear_log();
      rec.delete();
      sync_cnt = 0; last_cnt = 0; abort_cnt = 0;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_tvalid"}, m_axis_tvalid, 1'b0);
      chk({name, "_tdata"}, m_axis_tdata, 8'h00);
      chk({name, "_tlast"}, m_axis_tlast, 1'b0);
      chk({name, "_locked"}, locked, 1'b0);
      chk({name, "_sync_det"}, sync_det, 1'b0);
      chk({name, "_frame_abort"}, frame_abort, 1'b0);
   endtask

   always @(negedge aclk) begin : compare
      logic ev;
      if (chk_en && aresetn) begin
         ev = (exp_bytes.size() > 0) && (exp_bytes[0].c == cyc);
         chk("tvalid", m_axis_tvalid, ev);
         if (ev) begin
            chk("tdata", m_axis_tdata, exp_bytes[0].data);
            chk("tlast", m_axis_tlast, exp_bytes[0].last);
            void'(exp_bytes.pop_front());
         end else begin
            chk("tlast_idle", m_axis_tlast, 1'b0);
         end
         if (m_axis_tvalid) begin
            rec_t r;
            r.data = m_axis_tdata; r.last = m_axis_tlast;
            rec.push_back(r);
            if (m_axis_tlast) last_cnt++;
         end
         ev = (exp_sync.size() > 0) && (exp_sync[0] == cyc);
         chk("sync_det", sync_det, ev);
         if (ev) void'(exp_sync.pop_front());
         if (sync_det) sync_cnt++;
         ev = (exp_abort.size() > 0) && (exp_abort[0] == cyc);
         chk("frame_abort", frame_abort, ev);
         if (ev) void'(exp_abort.pop_front());
         if (frame_abort) abort_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int nz, nbytes, len;
      repeat (3) @(posedge aclk);
      #1;
      chk_all_zero("reset");
      @(negedge aclk); #2;
      aresetn = 1'b1;
      chk_en  = 1'b1;

      // 1: one bit per cycle
      clear_log();
      push_hdr(8'd3);
      push_byte(8'hA5, 1, 0); push_byte(8'h5A, 1, 0); push_byte(8'hFF, 1, 1);
      drive(1, 1000000);
      settle("t1");
      chk("t1_count", rec.size(), 3);
      chk("t1_b0", rec[0].data, 8'hA5);
      chk("t1_b1", rec[1].data, 8'h5A);
      chk("t1_b2", rec[2].data, 8'hFF);
      chk("t1_last", {rec[0].last, rec[1].last, rec[2].last}, 3'b001);
      chk("t1_sync_cnt", sync_cnt, 1);

      // 2: two bits per cycle, sync lands on the first bit of a pair
      clear_log();
      push_raw(1'b1);
      push_hdr(8'd2);
      push_byte(8'h0F, 1, 0); push_byte(8'hF0, 1, 1);
      drive(2, 1000000);
      settle("t2");
      chk("t2_count", rec.size(), 2);
      chk("t2_b0", rec[0].data, 8'h0F);
      chk("t2_b1", rec[1].data, 8'hF0);
      chk("t2_last", {rec[0].last, rec[1].last}, 2'b01);

      // 3: zero-length frame followed by a one-byte frame
      clear_log();
      push_hdr(8'd0);
      push_hdr(8'd1);
      push_byte(8'h77, 1, 1);
      drive(1, 1000000);
      settle("t3");
      chk("t3_count", rec.size(), 1);
      chk("t3_b0", rec[0].data, 8'h77);
      chk("t3_last_cnt", last_cnt, 1);
      chk("t3_sync_cnt", sync_cnt, 2);

      // 4: abort by num=3 inside a frame, then recover
      clear_log();
      push_hdr(8'd4);
      push_byte(8'h11, 1, 0); push_byte(8'h22, 1, 0);
      drive(1, 1000000);
      @(negedge aclk);
      chk("t4_locked_mid", locked, 1'b1);
      send_abort();
      chk("t4_locked_after", locked, 1'b0);
      settle("t4a");
      chk("t4_abort_cnt", abort_cnt, 1);
      chk("t4_last_cnt", last_cnt, 0);
      chk("t4_count", rec.size(), 2);
      push_hdr(8'd1);
      push_byte(8'h33, 1, 1);
      drive(1, 1000000);
      settle("t4b");
      chk("t4_count2", rec.size(), 3);
      chk("t4_b2", rec[2].data, 8'h33);
      chk("t4_last_cnt2", last_cnt, 1);

      // 5: 500 random frames, random 0..2 bits per cycle
      clear_log();
      nz = 0; nbytes = 0;
      for (int f = 0; f < 500; f++) begin
         len = int'($urandom_range(8, 0));
         if (len != 0) nz++;
         nbytes += len;
         push_hdr(8'(len));
         for (int i = 0; i < len; i++) push_byte(8'($urandom), 1, i == len - 1);
      end
      drive(0, 1000000);
      settle("t5");
      chk("t5_count", rec.size(), nbytes);
      chk("t5_last_cnt", last_cnt, nz);
      chk("t5_sync_cnt", sync_cnt, 500);

      // 6: asynchronous reset in the middle of a payload
      clear_log();
      push_hdr(8'd6);
      for (int i = 0; i < 6; i++) push_byte(8'($urandom), 1, i == 5);
      drive(1, 16 + 8 + 20);
      @(negedge aclk);
      chk("t6_locked_mid", locked, 1'b1);
      #2;
      aresetn = 1'b0;
      #1;
      chk_all_zero("t6_rst");
      bits_q.delete(); exp_bytes.delete(); exp_sync.delete(); exp_abort.delete();
      repeat (3) @(posedge aclk);
      #4;
      aresetn = 1'b1;
      rec.delete();
      settle("t6a");
      chk("t6_no_spurious", rec.size(), 0);
      push_hdr(8'd2);
      push_byte(8'hC3, 1, 0); push_byte(8'h3C, 1, 1);
      drive(2, 1000000);
      settle("t6b");
      chk("t6_count", rec.size(), 2);
      chk("t6_b0", rec[0].data, 8'hC3);
      chk("t6_b1", rec[1].data, 8'h3C);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
